// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears only the valid bit, load captures a new
// fetch bundle, otherwise everything holds.
module if_id_reg #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_load,
  input  logic                     i_flush,
  input  logic [DATA_WIDTH-1:0]    i_instr,
  input  logic [ADDRESS_WIDTH-1:0] i_pc,
  input  logic [ADDRESS_WIDTH-1:0] i_pc_plus4,
  output logic                     o_valid,
  output logic [DATA_WIDTH-1:0]    o_instr,
  output logic [ADDRESS_WIDTH-1:0] o_pc,
  output logic [ADDRESS_WIDTH-1:0] o_pc_plus4
);

  logic                     r_valid;
  logic [DATA_WIDTH-1:0]    r_instr;
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [ADDRESS_WIDTH-1:0] r_pc_plus4;

  // Flush wins over load so a redirect/halt never lets a stale word through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
    end
  end

  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch: PC register, BOOT/RUN/HALTED control and an
// IF/ID register fed from a combinational instruction ROM.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] instr_addr_o,
  input  logic [DATA_WIDTH-1:0]    instr_rdata_i,
  input  logic                     redirect_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  input  logic                     stall_i,
  input  logic                     halt_i,
  output logic                     if_valid_o,
  output logic [DATA_WIDTH-1:0]    if_instr_o,
  output logic [ADDRESS_WIDTH-1:0] if_pc_o,
  output logic [ADDRESS_WIDTH-1:0] if_pc_plus4_o,
  output logic                     halted_o
);

  localparam logic [ADDRESS_WIDTH-1:0] STEP  = ADDRESS_WIDTH'(INSTR_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN = ~ADDRESS_WIDTH'(INSTR_BYTES - 1);

  fetch_state_e             r_state;
  fetch_state_e             w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [ADDRESS_WIDTH-1:0] w_pc_next;
  logic [ADDRESS_WIDTH-1:0] w_pc_plus4;
  logic [ADDRESS_WIDTH-1:0] w_redirect_aligned;
  logic                     w_load;
  logic                     w_flush;

  // Wraps naturally at the top of the address space.
  assign w_pc_plus4         = r_pc + STEP;
  assign w_redirect_aligned = redirect_pc_i & ALIGN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Priority inside RUN: halt, then redirect, then stall, then fetch.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    unique case (r_state)
      BOOT: begin
        w_state_next = RUN;
        w_pc_next    = RESET_PC;
      end
      RUN: begin
        if (halt_i) begin
          w_state_next = HALTED;
          w_flush      = 1'b1;
        end else if (redirect_valid_i) begin
          w_pc_next = w_redirect_aligned;
          w_flush   = 1'b1;
        end else if (!stall_i) begin
          w_pc_next = w_pc_plus4;
          w_load    = 1'b1;
        end
      end
      HALTED: begin
        w_state_next = HALTED;
      end
      default: begin
        w_state_next = BOOT;
        w_pc_next    = RESET_PC;
      end
    endcase
  end

  if_id_reg #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_instr    (instr_rdata_i),
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .o_valid    (if_valid_o),
    .o_instr    (if_instr_o),
    .o_pc       (if_pc_o),
    .o_pc_plus4 (if_pc_plus4_o)
  );

  assign instr_addr_o = r_pc;
  assign halted_o     = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural fetch model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_rdata_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        halt_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus4_o;
  logic        halted_o;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Model of the architectural fetch state: 0 = boot, 1 = run, 2 = halted.
  int          m_state;
  logic [31:0] m_pc;
  logic        m_v;
  logic [31:0] m_instr, m_ipc, m_ip4;

  fetch_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'h0)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_addr_o     (instr_addr_o),
    .instr_rdata_i    (instr_rdata_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .stall_i          (stall_i),
    .halt_i           (halt_i),
    .if_valid_o       (if_valid_o),
    .if_instr_o       (if_instr_o),
    .if_pc_o          (if_pc_o),
    .if_pc_plus4_o    (if_pc_plus4_o),
    .halted_o         (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: bytes 0..3 are 13 05 00 00, everything else a fixed hash.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0) return 32'h1305_0000;
    return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ (a * 32'h9E37_79B9);
  endfunction

  assign instr_rdata_i = rom(instr_addr_o);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 32'h0;
    m_v     = 1'b0;
    m_instr = 32'h0;
    m_ipc   = 32'h0;
    m_ip4   = 32'h0;
  endtask

  // One clock of fetch behaviour from the rules: halt > redirect > stall > fetch.
  task automatic model_step();
    if (!rst_n) return;
    case (m_state)
      0: m_state = 1;
      1: begin
        if (halt_i) begin
          m_state = 2;
          m_v     = 1'b0;
        end else if (redirect_valid_i) begin
          m_pc = {redirect_pc_i[31:2], 2'b00};
          m_v  = 1'b0;
        end else if (!stall_i) begin
          m_instr = rom(m_pc);
          m_ipc   = m_pc;
          m_ip4   = m_pc + 32'd4;
          m_v     = 1'b1;
          m_pc    = m_pc + 32'd4;
        end
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("addr",   instr_addr_o,        m_pc);
      chk("valid",  32'(if_valid_o),     32'(m_v));
      chk("instr",  if_instr_o,          m_instr);
      chk("pc",     if_pc_o,             m_ipc);
      chk("pc4",    if_pc_plus4_o,       m_ip4);
      chk("halted", 32'(halted_o),       32'(m_state == 2));
    end
  end

  // Called at a negedge; drives inputs, advances one clock, returns at next negedge.
  task automatic cyc(input logic rd, input logic st, input logic hl, input logic [31:0] rp);
    redirect_valid_i = rd;
    stall_i          = st;
    halt_i           = hl;
    redirect_pc_i    = rp;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic rand_cyc();
    cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
        $urandom_range(0, 199) == 0, $urandom);
  endtask

  // Async reset mid-cycle; released on the next negedge.
  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid",  32'(if_valid_o), 32'h0);
    chk("rst_instr",  if_instr_o,      32'h0);
    chk("rst_pc",     if_pc_o,         32'h0);
    chk("rst_pc4",    if_pc_plus4_o,   32'h0);
    chk("rst_addr",   instr_addr_o,    32'h0);
    chk("rst_halted", 32'(halted_o),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'h0;
    stall_i          = 1'b0;
    halt_i           = 1'b0;
    model_reset();
    chk_en = 1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(if_valid_o), 32'h0);
    chk("reset_addr",  instr_addr_o,    32'h0);
    rst_n = 1'b1;

    // Boot cycle, then the first word lands.
    chk("boot_valid", 32'(if_valid_o), 32'h0);
    chk("boot_halted", 32'(halted_o), 32'h0);
    cyc(0, 0, 0, 0);
    chk("run1_valid", 32'(if_valid_o), 32'h0);
    cyc(0, 0, 0, 0);
    chk("first_instr", if_instr_o,    32'h1305_0000);
    chk("first_pc",    if_pc_o,       32'h0);
    chk("first_pc4",   if_pc_plus4_o, 32'h4);

    // Free run: 0, 4, 8, C.
    for (int i = 1; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      chk("seq_pc",    if_pc_o,          32'(4 * i));
      chk("seq_valid", 32'(if_valid_o),  32'h1);
    end

    // Redirect to 8, then stall three cycles with PC = 8.
    cyc(1, 0, 0, 32'h8);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      chk("stall_addr",  instr_addr_o,    32'h8);
      chk("stall_pc",    if_pc_o,         32'hC);
      chk("stall_valid", 32'(if_valid_o), 32'h0);
    end
    cyc(0, 0, 0, 0);
    chk("unstall_pc0", if_pc_o, 32'h8);
    cyc(0, 0, 0, 0);
    chk("unstall_pc1", if_pc_o, 32'hC);

    // Stall held across valid data.
    cyc(0, 1, 0, 0);
    chk("vstall_pc",    if_pc_o,         32'hC);
    chk("vstall_valid", 32'(if_valid_o), 32'h1);

    // Redirect beats stall; target low bits dropped.
    cyc(1, 1, 0, 32'h43);
    chk("redir_addr",  instr_addr_o,    32'h40);
    chk("redir_valid", 32'(if_valid_o), 32'h0);
    cyc(0, 0, 0, 0);
    chk("redir_pc",    if_pc_o,         32'h40);
    chk("redir_v1",    32'(if_valid_o), 32'h1);

    // Wrap of PC+4, then halt beats redirect.
    cyc(1, 0, 0, 32'hFFFF_FFFC);
    chk("top_addr", instr_addr_o, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("wrap_addr", instr_addr_o,  32'h0);
    chk("wrap_pc",   if_pc_o,       32'hFFFF_FFFC);
    chk("wrap_pc4",  if_pc_plus4_o, 32'h0);
    cyc(1, 0, 1, 32'h100);
    for (int i = 0; i < 10; i++) begin
      chk("halt_addr",   instr_addr_o,    32'h0);
      chk("halt_flag",   32'(halted_o),   32'h1);
      chk("halt_valid",  32'(if_valid_o), 32'h0);
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
    end

    // Reset out of HALTED, run to PC = 0x20, reset mid-run, restart.
    reset_pulse();
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0);
    chk("pre_rst_addr", instr_addr_o, 32'h20);
    reset_pulse();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("restart_pc",    if_pc_o,         32'h0);
    chk("restart_valid", 32'(if_valid_o), 32'h1);
    chk("restart_instr", if_instr_o,      32'h1305_0000);

    // Randomized traffic; occasional resets to leave HALTED.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0 || (m_state == 2 && $urandom_range(0, 15) == 0))
        reset_pulse();
      else
        rand_cyc();
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, PC and instruction-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 instr_addr_o  output  ADDRESS_WIDTH  byte address to instruction ROM; always equals the current PC.
REQ-008 instr_rdata_i  input  DATA_WIDTH  combinational ROM read data for instr_addr_o, valid in the same cycle.
REQ-009 redirect_valid_i  input  1  taken branch/jump request.
REQ-010 redirect_pc_i  input  ADDRESS_WIDTH  redirect target byte address.
REQ-011 stall_i  input  1  decode not ready; hold fetch state.
REQ-012 halt_i  input  1  stop fetching permanently until reset.
REQ-013 if_valid_o  output  1  IF/ID register holds a valid instruction.
REQ-014 if_instr_o  output  DATA_WIDTH  registered instruction word.
REQ-015 if_pc_o  output  ADDRESS_WIDTH  PC of if_instr_o.
REQ-016 if_pc_plus4_o  output  ADDRESS_WIDTH  if_pc_o + 4, registered.
REQ-017 halted_o  output  1  high while in HALTED.

Function
REQ-018 SHALL implement states BOOT, RUN and HALTED.
REQ-019 BOOT SHALL last exactly one cycle after reset release: PC = RESET_PC, no capture, if_valid_o = 0, next state RUN.
REQ-020 In RUN, with no redirect, stall or halt, each cycle SHALL load IF/ID with {instr_rdata_i, PC, PC+4}, set if_valid_o = 1 and advance PC by 4.
REQ-021 Fetch latency SHALL be one cycle: the word addressed in cycle N appears on if_instr_o in cycle N+1.
REQ-022 PC+4 SHALL wrap modulo 2^ADDRESS_WIDTH (all-ones minus 3 -> 0), with no flag.
REQ-023 With stall_i = 1 and no redirect, PC and all IF/ID outputs SHALL hold unchanged, including if_valid_o.
REQ-024 redirect_valid_i SHALL have priority over stall_i: PC <= redirect_pc_i with bits [1:0] forced to 00, and if_valid_o <= 0 in the next cycle (flush).
REQ-025 The first instruction after a redirect SHALL appear on if_instr_o two cycles after the redirect cycle.
REQ-026 halt_i in RUN SHALL have priority over redirect and stall: next state HALTED, if_valid_o <= 0, PC held.
REQ-027 HALTED SHALL be absorbing: PC and IF/ID frozen, if_valid_o = 0, halted_o = 1; redirect_valid_i, stall_i and halt_i ignored.
REQ-028 redirect_valid_i, stall_i and halt_i SHALL be ignored during BOOT.
REQ-029 instr_addr_o SHALL be driven from the PC register with no combinational path from any input.

Reset
REQ-030 While rst_n = 0: state = BOOT, PC = RESET_PC, if_valid_o = 0, if_instr_o = 0, if_pc_o = 0, if_pc_plus4_o = 0, halted_o = 0.
REQ-031 Reset assertion mid-operation SHALL take effect immediately and asynchronously, discarding any in-flight instruction.
REQ-032 Reset release SHALL be synchronous to clk through the BOOT cycle.

Structure
REQ-033 A shared package fetch_pkg SHALL hold the state enum (BOOT, RUN, HALTED) and the constant INSTR_BYTES = 4.
REQ-034 The IF/ID register SHALL be a sub-module if_id_reg with load, flush and hold controls; PC logic and the FSM SHALL stay in fetch_unit.

Verification
REQ-035 Reset, then release, with ROM bytes 0..3 = 13 05 00 00 -> cycle 1 BOOT with if_valid_o = 0; cycle 2 if_instr_o = 0x13050000, if_pc_o = 0, if_pc_plus4_o = 4.
REQ-036 Free run for 4 cycles -> if_pc_o sequence 0, 4, 8, 0xC with valid = 1 on every cycle.
REQ-037 stall_i high for 3 cycles at PC = 8 -> instr_addr_o stays 8 and IF/ID outputs are unchanged; on release if_pc_o = 8, then 0xC.
REQ-038 redirect_pc_i = 0x43 together with stall_i = 1 -> PC = 0x40, next cycle if_valid_o = 0, following cycle if_pc_o = 0x40.
REQ-039 PC = 0xFFFFFFFC, free run -> next instr_addr_o = 0; halt_i together with redirect -> HALTED, halted_o = 1, PC frozen for 10 cycles.
REQ-040 rst_n pulsed low mid-run at PC = 0x20 -> outputs clear in the same cycle; after release, fetch restarts at RESET_PC.
